// File: rtl/mem_access.sv
// Memory-phase load/store unit: issues one req/ack data-memory access per memory
// phase, aligns byte lanes and extends load data for the data register.
module mem_access #(
  parameter int MAX_WAIT = 255,
  parameter int PHASE_H  = 4,
  parameter int M_BIT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASE_H:0]  phase,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              ld,
  input  logic              st,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        start;
  logic        illegal;
  logic        timeout;
  logic        is_load;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        sign_q;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic        unused_phase;

  assign unused_phase = ^phase;

  assign start   = phase[M_BIT] && (ld || st) && (state == IDLE);
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    illegal = 1'b0;
    if (ld && st)
      illegal = 1'b1;
    else begin
      case (size)
        2'b00:   illegal = 1'b0;
        2'b01:   illegal = addr[0];
        2'b10:   illegal = (addr[1:0] != 2'b00);
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = 32'd0;
    case (size)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      2'b10: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
      default: begin
        be_calc    = 4'b0000;
        wdata_calc = 32'd0;
      end
    endcase
  end

  // Lane selection uses the registered access shape, so CPU inputs may move during REQ.
  always_comb begin
    rdata_shifted = mem_rdata >> {lane_q, 3'b000};
    load_ext      = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = {{16{sign_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)
          state_next = illegal ? ERR : REQ;
      end
      REQ: begin
        if (mem_ack)
          state_next = DONE;
        else if (timeout)
          state_next = ERR;
      end
      DONE, ERR: begin
        if (!phase[M_BIT])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = !rst && (start || (state == REQ));
    fault = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      wait_cnt  <= 8'd0;
      is_load   <= 1'b0;
      size_q    <= 2'd0;
      lane_q    <= 2'd0;
      sign_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (start) begin
            if (illegal) begin
              load_data <= 32'd0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= st;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
              is_load   <= ld;
              size_q    <= size;
              lane_q    <= addr[1:0];
              sign_q    <= sign_ext;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load)
              load_data <= load_ext;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            load_data <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
